// File: rtl/i2c_pkg.sv
// Shared types and register offsets for the MMIO I2C master core.
// Command codes match the software-visible encoding in wr_data[10:8].
package i2c_pkg;

  typedef enum logic [2:0] {
    CmdStart   = 3'd0,
    CmdWr      = 3'd1,
    CmdRd      = 3'd2,
    CmdStop    = 3'd3,
    CmdRestart = 3'd4
  } i2c_cmd_t;

  typedef enum logic [3:0] {
    StIdle,
    StStart1,
    StStart2,
    StHold,
    StData1,
    StData2,
    StData3,
    StData4,
    StRestart,
    StStop1,
    StStop2
  } i2c_state_t;

  localparam logic [4:0] I2C_REG_STATUS = 5'd0;
  localparam logic [4:0] I2C_REG_DVSR   = 5'd1;
  localparam logic [4:0] I2C_REG_CMD    = 5'd2;

endpackage

// File: rtl/i2c_master_core.sv
// Byte-level I2C master: software issues start/write/read/stop/restart commands,
// the core sequences SCL/SDA in quarter-bit phases of dvsr+1 clocks each.
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int unsigned DVSR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output tri          scl,
  inout  tri          sda
);

  i2c_state_t        state_q, state_d;
  logic [DVSR_W-1:0] phase_q, phase_d;
  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic [3:0]        bit_q, bit_d;
  logic [8:0]        tx_q, tx_d;
  logic [8:0]        rx_q, rx_d;
  logic              is_rd_q, is_rd_d;
  logic [7:0]        dout_q, dout_d;
  logic              ack_q, ack_d;
  logic              sda_hold_q;

  logic       ready;
  logic       cmd_we;
  logic [2:0] cmd_code;
  logic [7:0] din;
  logic       phase_last;
  logic       scl_low, sda_low;
  logic       sda_in;
  logic       unused_inputs;

  assign unused_inputs = ^{read, wr_data};

  assign sda_in     = sda;
  assign cmd_we     = cs && write && (addr == I2C_REG_CMD);
  assign cmd_code   = wr_data[10:8];
  assign din        = wr_data[7:0];
  assign phase_last = (phase_q == dvsr_q);
  assign ready      = (state_q == StIdle) || (state_q == StHold);

  always_comb begin
    dvsr_d = dvsr_q;
    if (cs && write && (addr == I2C_REG_DVSR) && ready) begin
      dvsr_d = wr_data[DVSR_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    is_rd_d = is_rd_q;
    dout_d  = dout_q;
    ack_d   = ack_q;
    scl_low = 1'b0;
    sda_low = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_we && (cmd_code == CmdStart)) state_d = StStart1;
      end
      StStart1: begin
        sda_low = 1'b1;
        if (phase_last) state_d = StStart2;
      end
      StStart2: begin
        scl_low = 1'b1;
        sda_low = 1'b1;
        if (phase_last) state_d = StHold;
      end
      StHold: begin
        scl_low = 1'b1;
        sda_low = sda_hold_q;
        if (cmd_we) begin
          case (cmd_code)
            CmdWr: begin
              state_d = StData1;
              bit_d   = 4'd0;
              tx_d    = {din, 1'b1};
              is_rd_d = 1'b0;
            end
            CmdRd: begin
              // Data bits released for the slave; bit 8 carries our ACK/NACK.
              state_d = StData1;
              bit_d   = 4'd0;
              tx_d    = {8'hff, din[0]};
              is_rd_d = 1'b1;
            end
            CmdStop:    state_d = StStop1;
            CmdRestart: state_d = StRestart;
            default:    state_d = StHold;
          endcase
        end
      end
      StData1: begin
        scl_low = 1'b1;
        sda_low = ~tx_q[8];
        if (phase_last) state_d = StData2;
      end
      StData2: begin
        sda_low = ~tx_q[8];
        if (phase_last) begin
          rx_d    = {rx_q[7:0], sda_in};
          state_d = StData3;
        end
      end
      StData3: begin
        sda_low = ~tx_q[8];
        if (phase_last) state_d = StData4;
      end
      StData4: begin
        scl_low = 1'b1;
        sda_low = ~tx_q[8];
        if (phase_last) begin
          if (bit_q == 4'd8) begin
            state_d = StHold;
            if (is_rd_q) dout_d = rx_q[8:1];
            else         ack_d  = rx_q[0];
          end else begin
            state_d = StData1;
            bit_d   = bit_q + 4'd1;
            tx_d    = {tx_q[7:0], 1'b1};
          end
        end
      end
      StRestart: begin
        if (phase_last) state_d = StStart1;
      end
      StStop1: begin
        sda_low = 1'b1;
        if (phase_last) state_d = StStop2;
      end
      StStop2: begin
        if (phase_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if ((state_d != state_q) || (state_q == StIdle) || (state_q == StHold)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + DVSR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      dvsr_q     <= '0;
      bit_q      <= 4'd0;
      tx_q       <= 9'h1ff;
      rx_q       <= 9'h000;
      is_rd_q    <= 1'b0;
      dout_q     <= 8'h00;
      ack_q      <= 1'b0;
      sda_hold_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dvsr_q  <= dvsr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      is_rd_q <= is_rd_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      // HOLD keeps driving whatever SDA level the previous state left behind.
      if (state_q != StHold) sda_hold_q <= sda_low;
    end
  end

  assign rd_data = {22'b0, ready, ack_q, dout_q};

  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_core.sv
// Self-checking bench for i2c_master_core: command table plus randomized byte traffic,
// with an open-drain bus, a simple slave and a transaction-level reference model.
`timescale 1ns/1ps
module tb_i2c_master_core;

  localparam logic [2:0] C_START = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_STOP = 3'd3,
                         C_RESTART = 3'd4;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  tri          scl, sda;

  pullup (scl);
  pullup (sda);

  // Slave: bit i of the current byte is sb[i] (1 = released), advanced on each SCL fall.
  logic [9:0] sb = 10'h3ff;
  int         slave_idx = 9;
  assign sda = sb[slave_idx] ? 1'bz : 1'b0;

  i2c_master_core #(.DVSR_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .scl     (scl),
    .sda     (sda)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int m_d = 0;
  logic m_ack = 1'b0;
  logic [7:0] m_dout = 8'h00;

  // Bus monitor state, owned by the monitor process.
  int cyc = 0, start_ev = 0, stop_ev = 0, t_start = 0, t_sclfall = 0;
  int arm = 0, arm_seen = 0, rise_n = 0;
  logic [8:0] rise_bits = 9'h1ff;
  logic p_scl = 1'b1, p_sda = 1'b1;

  initial begin
    logic s_scl, s_sda;
    forever begin
      @(negedge clk);
      s_scl = scl;
      s_sda = sda;
      cyc++;
      if (arm != arm_seen) begin
        arm_seen  = arm;
        slave_idx = 0;
        rise_n    = 0;
        rise_bits = 9'h1ff;
      end
      if (!p_scl && s_scl === 1'b1) begin
        if (rise_n < 9) rise_bits[8-rise_n] = s_sda;
        rise_n++;
      end
      if (p_scl && s_scl === 1'b0) begin
        t_sclfall = cyc;
        if (slave_idx < 9) slave_idx++;
      end
      if (p_scl && s_scl === 1'b1 && p_sda && s_sda === 1'b0) begin
        start_ev++;
        t_start = cyc;
      end
      if (p_scl && s_scl === 1'b1 && !p_sda && s_sda === 1'b1) stop_ev++;
      p_scl = s_scl;
      p_sda = s_sda;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  function automatic logic [31:0] m_status();
    return {22'b0, 1'b1, m_ack, m_dout};
  endfunction

  function automatic int lat_of(input logic [2:0] c);
    if (c == C_WR || c == C_RD) return 36;
    if (c == C_RESTART)         return 3;
    return 2;
  endfunction

  task automatic ign_cmd(input logic [2:0] code);
    wr_reg(5'd2, {21'b0, code, 8'h55});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("ignored_cmd", rd_data, m_status());
  endtask

  // inj: 0 none, 1 STOP command mid-byte, 2 dvsr write mid-byte (both must be ignored).
  task automatic do_cmd(input logic [2:0] cmd, input logic [7:0] din, input logic [7:0] sbyte,
                        input logic sack, input int inj, input int lat);
    logic [8:0] exp_bits;
    logic       m, s;
    int         cnt, s0, p0, budget;
    bit         is_byte;
    is_byte = (cmd == C_WR) || (cmd == C_RD);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        m = (cmd == C_WR) ? din[7-i] : 1'b1;
        s = (cmd == C_RD) ? sbyte[7-i] : 1'b1;
      end else begin
        m = (cmd == C_RD) ? din[0] : 1'b1;
        s = (cmd == C_WR) ? sack : 1'b1;
      end
      sb[i] = s;
      exp_bits[8-i] = m & s;
    end
    sb[9] = 1'b1;
    if (!is_byte) sb = 10'h3ff;
    arm++;
    s0 = start_ev;
    p0 = stop_ev;
    wr_reg(5'd2, {21'b0, cmd, din});
    cnt = 0;
    budget = 40 * (m_d + 1) + 20;
    while (rd_data[9] !== 1'b1 && cnt < budget) begin
      @(posedge clk);
      #1;
      cs = 1'b0; write = 1'b0;
      cnt++;
      if (inj != 0 && cnt == 20) begin
        cs = 1'b1; write = 1'b1;
        addr    = (inj == 1) ? 5'd2 : 5'd1;
        wr_data = (inj == 1) ? {21'b0, C_STOP, 8'h00} : 32'd0;
      end
    end
    cs = 1'b0; write = 1'b0;
    chk("latency", 32'(cnt), 32'(lat * (m_d + 1)));
    if (cmd == C_WR) m_ack  = exp_bits[0];
    if (cmd == C_RD) m_dout = exp_bits[8:1];
    if (is_byte) begin
      chk("sda_at_scl_rise", {15'b0, 8'(rise_n), rise_bits}, {15'b0, 8'd9, exp_bits});
      chk("hold_pins", {30'b0, scl, sda}, {30'b0, 1'b0, (cmd == C_RD) ? din[0] : 1'b1});
    end
    if (cmd == C_START || cmd == C_RESTART) begin
      chk("start_cond", 32'(start_ev - s0), 32'd1);
      chk("start_scl_delay", 32'(t_sclfall - t_start), 32'(m_d + 1));
    end
    if (cmd == C_STOP) begin
      chk("stop_cond", 32'(stop_ev - p0), 32'd1);
      chk("idle_pins", {30'b0, scl, sda}, 32'd3);
    end
    chk("status", rd_data, m_status());
  endtask

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] din;
    logic [7:0] sbyte;
    logic       sack;
    int         inj;
    int         lat;
  } vec_t;

  vec_t tv [8];

  initial begin
    int r;
    logic [2:0] c;
    tv[0] = '{C_START,   8'h00, 8'h00, 1'b1, 0, 2};
    tv[1] = '{C_WR,      8'hA5, 8'h00, 1'b0, 0, 36};
    tv[2] = '{C_WR,      8'h3C, 8'h00, 1'b1, 0, 36};
    tv[3] = '{C_RD,      8'h01, 8'h96, 1'b1, 1, 36};
    tv[4] = '{C_RESTART, 8'h00, 8'h00, 1'b1, 0, 3};
    tv[5] = '{C_WR,      8'h5A, 8'h00, 1'b0, 2, 36};
    tv[6] = '{C_RD,      8'h00, 8'h3C, 1'b1, 0, 36};
    tv[7] = '{C_STOP,    8'h00, 8'h00, 1'b1, 0, 2};

    cs = 1'b0; write = 1'b0; read = 1'b1; addr = 5'd0; wr_data = 32'd0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 32'h0000_0200);
    chk("reset_pins", {30'b0, scl, sda}, 32'd3);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    ign_cmd(C_WR);
    ign_cmd(C_RD);
    ign_cmd(C_STOP);

    wr_reg(5'd1, 32'd4);
    m_d = 4;
    foreach (tv[i]) do_cmd(tv[i].cmd, tv[i].din, tv[i].sbyte, tv[i].sack, tv[i].inj, tv[i].lat);

    m_d = $urandom_range(0, 3);
    wr_reg(5'd1, 32'(m_d));
    do_cmd(C_START, 8'h00, 8'h00, 1'b1, 0, lat_of(C_START));
    for (int k = 0; k < 14; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) c = C_WR;
      else if (r < 8) c = C_RD;
      else if (r == 8) c = C_RESTART;
      else c = 3'd7;
      if (c == 3'd7) begin
        ign_cmd(($urandom_range(0, 1) == 0) ? C_START : 3'($urandom_range(5, 7)));
      end else begin
        do_cmd(c, 8'($urandom), 8'($urandom), 1'($urandom), (c == C_RESTART) ? 0 :
               $urandom_range(0, 2), lat_of(c));
      end
    end
    do_cmd(C_STOP, 8'h00, 8'h00, 1'b1, 0, lat_of(C_STOP));

    // Reset in the middle of bit 4 of a write, with SCL and SDA both pulled low.
    wr_reg(5'd1, 32'd4);
    m_d = 4;
    do_cmd(C_START, 8'h00, 8'h00, 1'b1, 0, 2);
    sb = 10'h3ff;
    wr_reg(5'd2, {21'b0, C_WR, 8'h00});
    repeat (82) begin
      @(posedge clk);
      #1;
    end
    chk("mid_wr_pins", {30'b0, scl, sda}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_mid_op_pins", {30'b0, scl, sda}, 32'd3);
    chk("reset_mid_op_rd_data", rd_data, 32'h0000_0200);
    @(negedge clk);
    reset = 1'b0;
    m_d = 0; m_ack = 1'b0; m_dout = 8'h00;
    do_cmd(C_START, 8'h00, 8'h00, 1'b1, 0, 2);
    do_cmd(C_STOP, 8'h00, 8'h00, 1'b1, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_master_core.md
# i2c_master_core

Memory-mapped I2C master core that plugs into one slot of the MMIO subsystem, between the FPro bus slot decode and the board's open-drain `scl`/`sda` pins. Software sets the bus clock divisor, then issues byte-level commands (start, write, read, stop, restart) and polls a ready/ack/data status word. The core generates all bit-level SCL/SDA sequencing with a quarter-period timer and a single FSM.

## Interface
- `DVSR_W`, 16: width of the quarter-SCL-period divisor register.
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `cs`  in  1  slot chip select.
- `read`  in  1  read strobe. Reads have no side effects.
- `write`  in  1  write strobe, qualified by `cs`.
- `addr`  in  5  register offset within the slot.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  read data, combinational from internal registers.
- `scl`  out (tri)  1  open-drain clock. Only ever driven 0 or released to Z.
- `sda`  inout (tri)  1  open-drain data. Only ever driven 0 or released to Z.

## Operation
- Register map:
  - offset 0, read: `{22'b0, ready, ack, dout[7:0]}`.
  - offset 1, write: `dvsr <= wr_data[DVSR_W-1:0]`.
  - offset 2, write: command `{cmd = wr_data[10:8], din = wr_data[7:0]}`.
  - Writes to other offsets are ignored.
- Command codes: START=0, WR=1, RD=2, STOP=3, RESTART=4. Codes 5-7 are ignored.
- Writes to the dvsr register while `ready`=0 are ignored.
- Command writes while `ready`=0 are ignored.
- In IDLE, only START is accepted. In HOLD, WR, RD, STOP and RESTART are accepted; START is ignored.
- `ready` = 1 in IDLE and HOLD, 0 in every other state.
- FSM states: IDLE, START1, START2, HOLD, DATA1, DATA2, DATA3, DATA4, RESTART, STOP1, STOP2. Each non-idle, non-hold state lasts exactly `dvsr+1` clocks, counted by a phase counter that clears on every state change.
- Pin levels and transitions per state:
  - IDLE: scl=Z, sda=Z.
  - START1: scl=Z, sda=0. Goes to START2.
  - START2: scl=0, sda=0. Goes to HOLD.
  - HOLD: scl=0, sda holds its last value.
  - DATA1: scl=0, sda = current bit.
  - DATA2: scl=Z, sda = current bit.
  - DATA3: scl=Z, sda = current bit.
  - DATA4: scl=0, sda = current bit.
  - RESTART: scl=Z, sda=Z. Goes to START1.
  - STOP1: scl=Z, sda=0. Goes to STOP2.
  - STOP2: scl=Z, sda=Z. Goes to IDLE.
- Byte transfer: 9 bits, each one DATA1→DATA4 sequence. A 4-bit bit counter runs 0..8. After DATA4 of bit 8 the FSM returns to HOLD; otherwise it goes to DATA1 of the next bit.
- WR:
  - Bits 0-7 drive `din` MSB first.
  - Bit 8: sda released; `ack` <= sampled sda.
- RD:
  - Bits 0-7: sda released, sampled bits shift into `dout` MSB first.
  - Bit 8 drives `din[0]` (0 = ACK, 1 = NACK); `ack` unchanged.
- Sampling point: the last clock of DATA2.
- `dout` changes only on RD; `ack` changes only on WR.

## Timing
- Reset values:
  - state IDLE, scl=Z, sda=Z.
  - `dvsr`=0, `dout`=0, `ack`=0, `ready`=1, so `rd_data`=0x0000_0200.
- A command write at clock edge n makes `ready`=0 from edge n+1. The new state's first phase starts at n+1.
- Latencies with D = `dvsr`:
  - START: 2(D+1) clocks.
  - RESTART: 3(D+1) clocks.
  - STOP: 2(D+1) clocks.
  - WR or RD: 36(D+1) clocks.
  - Each latency ends with `ready`=1 on the cycle the FSM enters HOLD or IDLE.
- SCL frequency = f_clk / (4(D+1)).
- dvsr=0 is legal and gives a 4-clock bit.
- Reset asserted mid-operation: both pins release on the next clock edge, and every register returns to its reset value.
- `rd_data` reflects the state updated at edge n in the same cycle after edge n. There is no read latency.

## Structure
- Package `i2c_pkg` holds:
  - the command enum `i2c_cmd_t` (3 bits, five codes);
  - the state enum `i2c_state_t`;
  - register offset constants `I2C_REG_STATUS`=0, `I2C_REG_DVSR`=1, `I2C_REG_CMD`=2.
- One module, no sub-module. Phase counter, bit counter, shift register and FSM all stay in one file.
- Tri-state conversion is done inside the core: drive 0 or Z.

## Test plan
- Reset, with pullups on both pins → scl=1, sda=1, `rd_data`=0x0000_0200. Command codes 1/2/3 written in IDLE are ignored (`ready` stays 1).
- dvsr=4, then START → `ready`=0 for 10 clocks. sda falls while scl is high; scl falls 5 clocks later; `ready`=1 in HOLD.
- WR 0xA5, slave model ACKs → on scl rising edges sda reads 1,0,1,0,0,1,0,1, then released. `ready` returns after 180 clocks with `ack`=0.
- WR 0x3C, no slave → `ack`=1, `dout` unchanged.
- RD with din=0x01, slave drives 0x96 → `dout`=0x96, master releases sda (NACK) on bit 8. A second command written mid-byte is ignored.
- STOP → sda rises while scl is high; state IDLE, `ready`=1. Separately, reset asserted during bit 4 of a WR → pins released on the next edge and `rd_data`=0x0000_0200.
